// File: rtl/ahb_resp_mux.sv
// AHB data-phase return mux: registers the address-phase HSEL and steers the
// selected slave's response back to the master, with a built-in default slave.
module ahb_resp_mux #(
    parameter int NSLV      = 5,
    parameter int DW        = 32,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NSLV-1:0]      HSEL,
    input  logic [1:0]           HTRANS,
    input  logic [NSLV*DW-1:0]   HRDATA_S,
    input  logic [NSLV-1:0]      HREADYOUT_S,
    input  logic [NSLV*2-1:0]    HRESP_S,
    output logic [DW-1:0]        HRDATA,
    output logic                 HREADY,
    output logic [1:0]           HRESP,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic [1:0]           ds_state
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    localparam logic [NSLV-1:0] SEL_ONE = NSLV'(1);

    ds_state_t       state;
    logic [NSLV-1:0] sel_q;
    logic            ds_hit;
    logic            hsel_onehot;
    logic            sel_q_onehot;
    logic            err_req;
    logic            enter_err;

    assign hsel_onehot  = (HSEL != '0) && ((HSEL & (HSEL - SEL_ONE)) == '0);
    assign sel_q_onehot = (sel_q != '0) && ((sel_q & (sel_q - SEL_ONE)) == '0);
    assign err_req      = !hsel_onehot && HTRANS[1];
    // A new error can only start on an address-capture edge (HREADY high).
    assign enter_err    = HREADY && err_req;
    assign ds_state     = state;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q   <= '0;
            ds_hit  <= 1'b0;
            state   <= DS_IDLE;
            ERR_CNT <= '0;
        end else begin
            if (HREADY) begin
                sel_q  <= HSEL;
                ds_hit <= err_req;
            end
            case (state)
                DS_IDLE, DS_ERR2: state <= enter_err ? DS_ERR1 : DS_IDLE;
                DS_ERR1:          state <= DS_ERR2;
                default:          state <= DS_IDLE;
            endcase
            if (enter_err && (ERR_CNT != '1)) begin
                ERR_CNT <= ERR_CNT + 1'b1;
            end
        end
    end

    // ds_hit is set exactly while the default slave owns the data phase
    // (DS_ERR1 and DS_ERR2); the first cycle stalls, the second completes.
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = 2'b00;
        if (ds_hit) begin
            HREADY = (state != DS_ERR1);
            HRESP  = 2'b01;
        end else if (sel_q_onehot) begin
            for (int i = 0; i < NSLV; i++) begin
                if (sel_q[i]) begin
                    HRDATA = HRDATA_S[i*DW +: DW];
                    HREADY = HREADYOUT_S[i];
                    HRESP  = HRESP_S[i*2 +: 2];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed bench for ahb_resp_mux: slave steering, wait states, default-slave
// ERROR sequences, async reset abort and error-counter saturation.
module tb_ahb_resp_mux;

    localparam int NSLV = 5;
    localparam int DW   = 32;
    localparam int CW   = 3;

    logic                HCLK = 1'b0;
    logic                HRESETn;
    logic [NSLV-1:0]     HSEL;
    logic [1:0]          HTRANS;
    logic [NSLV*DW-1:0]  HRDATA_S;
    logic [NSLV-1:0]     HREADYOUT_S;
    logic [NSLV*2-1:0]   HRESP_S;
    logic [DW-1:0]       HRDATA;
    logic                HREADY;
    logic [1:0]          HRESP;
    logic [CW-1:0]       ERR_CNT;
    logic [1:0]          ds_state;

    int errors = 0;
    int checks = 0;

    ahb_resp_mux #(.NSLV(NSLV), .DW(DW), .ERR_CNT_W(CW)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSEL        (HSEL),
        .HTRANS      (HTRANS),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .ERR_CNT     (ERR_CNT),
        .ds_state    (ds_state)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input logic rdy, input logic [1:0] rsp,
                            input logic [31:0] dat);
        chk({tag, "_hready"}, {31'd0, HREADY}, {31'd0, rdy});
        chk({tag, "_hresp"},  {30'd0, HRESP},  {30'd0, rsp});
        chk({tag, "_hrdata"}, HRDATA, dat);
    endtask

    initial begin
        HRESETn     = 1'b0;
        HSEL        = '0;
        HTRANS      = 2'b00;
        HREADYOUT_S = '1;
        HRESP_S     = '0;
        for (int i = 0; i < NSLV; i++) HRDATA_S[i*DW +: DW] = 32'hA5A5_0000 + i;

        // Reset values
        #12;
        chk_resp("rst", 1'b1, 2'b00, 32'h0);
        chk("rst_errcnt", {29'd0, ERR_CNT}, 32'd0);
        chk("rst_state", {30'd0, ds_state}, 32'd0);
        HRESETn = 1'b1;

        // IDLE to slave 0: zero-wait OKAY with slave 0 data
        HSEL = 5'b00001; HTRANS = 2'b00;
        tick();
        chk_resp("s0", 1'b1, 2'b00, 32'hA5A5_0000);
        chk("s0_errcnt", {29'd0, ERR_CNT}, 32'd0);

        // NONSEQ to slave 2 with two wait states; HSEL change during wait ignored
        HSEL = 5'b00100; HTRANS = 2'b10; HREADYOUT_S[2] = 1'b0;
        tick();
        chk_resp("s2_w1", 1'b0, 2'b00, 32'hA5A5_0002);
        HSEL = 5'b00010; HTRANS = 2'b10;
        tick();
        chk_resp("s2_w2", 1'b0, 2'b00, 32'hA5A5_0002);
        HREADYOUT_S[2] = 1'b1;
        #1;
        chk_resp("s2_done", 1'b1, 2'b00, 32'hA5A5_0002);
        tick();
        chk_resp("s1_after_wait", 1'b1, 2'b00, 32'hA5A5_0001);

        // NONSEQ to unmapped: two-cycle ERROR then OKAY
        HSEL = 5'b00000; HTRANS = 2'b10;
        tick();
        HTRANS = 2'b00;
        chk_resp("e1_c1", 1'b0, 2'b01, 32'h0);
        chk("e1_state1", {30'd0, ds_state}, 32'd1);
        chk("e1_errcnt", {29'd0, ERR_CNT}, 32'd1);
        tick();
        chk_resp("e1_c2", 1'b1, 2'b01, 32'h0);
        chk("e1_state2", {30'd0, ds_state}, 32'd2);
        tick();
        chk_resp("e1_after", 1'b1, 2'b00, 32'h0);
        chk("e1_state_idle", {30'd0, ds_state}, 32'd0);

        // BUSY then IDLE with non-one-hot HSEL: zero-wait OKAY, no count
        HSEL = 5'b00011; HTRANS = 2'b01;
        tick();
        chk_resp("busy", 1'b1, 2'b00, 32'h0);
        HTRANS = 2'b00;
        tick();
        chk_resp("idle_nh", 1'b1, 2'b00, 32'h0);
        chk("idle_errcnt", {29'd0, ERR_CNT}, 32'd1);

        // Back-to-back NONSEQ/SEQ errors, then slave 3 captured in DS_ERR2
        HRESP_S[3*2 +: 2] = 2'b10;
        HSEL = 5'b00000; HTRANS = 2'b10;
        tick();
        chk_resp("bb_a1", 1'b0, 2'b01, 32'h0);
        HTRANS = 2'b11;
        tick();
        chk_resp("bb_a2", 1'b1, 2'b01, 32'h0);
        chk("bb_cnt_a", {29'd0, ERR_CNT}, 32'd2);
        tick();
        chk_resp("bb_b1", 1'b0, 2'b01, 32'h0);
        chk("bb_cnt_b", {29'd0, ERR_CNT}, 32'd3);
        HSEL = 5'b01000; HTRANS = 2'b10;
        tick();
        chk_resp("bb_b2", 1'b1, 2'b01, 32'h0);
        HTRANS = 2'b00;
        tick();
        chk_resp("s3_retry", 1'b1, 2'b10, 32'hA5A5_0003);
        chk("s3_state", {30'd0, ds_state}, 32'd0);
        chk("s3_errcnt", {29'd0, ERR_CNT}, 32'd3);
        HRESP_S[3*2 +: 2] = 2'b00;

        // Async reset in the middle of DS_ERR1
        HSEL = 5'b00000; HTRANS = 2'b10;
        tick();
        chk_resp("ar_err1", 1'b0, 2'b01, 32'h0);
        HSEL = 5'b00001; HTRANS = 2'b00;
        #1 HRESETn = 1'b0;
        #1;
        chk_resp("ar_async", 1'b1, 2'b00, 32'h0);
        chk("ar_errcnt", {29'd0, ERR_CNT}, 32'd0);
        chk("ar_state", {30'd0, ds_state}, 32'd0);
        #1 HRESETn = 1'b1;
        tick();
        chk_resp("ar_after", 1'b1, 2'b00, 32'hA5A5_0000);

        // Saturation: 7 errors reach all-ones, two more must not wrap
        for (int n = 0; n < 9; n++) begin
            HSEL = 5'b00000; HTRANS = 2'b10;
            tick();
            HTRANS = 2'b00;
            tick();
            if (n == 6) chk("sat_reach", {29'd0, ERR_CNT}, 32'd7);
        end
        chk("sat_hold", {29'd0, ERR_CNT}, 32'd7);
        chk_resp("sat_err2", 1'b1, 2'b01, 32'h0);
        tick();
        chk_resp("sat_idle", 1'b1, 2'b00, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
